// File: rtl/json_hw_pkg.sv
// Shared types for the JSON hardware decode path: decoder error codes and
// the document arbiter state encoding.
package json_hw_pkg;

  typedef enum logic [3:0] {
    JSON_ERR_NONE           = 4'd0,
    JSON_ERR_EOF_VALUE      = 4'd1,
    JSON_ERR_EOF_OBJECT     = 4'd2,
    JSON_ERR_EOF_ARRAY      = 4'd3,
    JSON_ERR_EOF_STRING     = 4'd4,
    JSON_ERR_EXPECT_VALUE   = 4'd5,
    JSON_ERR_TRAILING_CHARS = 4'd6,
    JSON_ERR_INVALID_CHAR   = 4'd7,
    JSON_ERR_INVALID_NUMBER = 4'd8,
    JSON_ERR_DEPTH_LIMIT    = 4'd9,
    JSON_ERR_TIMEOUT        = 4'd15
  } json_err_e;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_WAIT,
    ARB_DRAIN,
    ARB_RESP
  } arb_state_e;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/json_rr_picker.sv
// Combinational round-robin select: first set bit of req_i searching
// cyclically from last_grant_i+1.
module json_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] c;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    c       = '0;
    // k == N wraps back to last_grant itself, so it is checked last
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(last_grant_i) + k) % N);
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/json_decode_arbiter.sv
// Shares one streaming JSON decoder among N_REQ byte sources, one whole
// document per grant, and routes the decoder verdict back to the owner.
module json_decode_arbiter
  import json_hw_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 1024,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    dec_valid,
  output logic [DATA_W-1:0]       dec_data,
  output logic                    dec_last,
  input  logic                    dec_ready,
  output logic                    dec_abort,
  input  logic                    dec_res_valid,
  input  logic                    dec_res_ok,
  input  logic [3:0]              dec_res_err,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic                    rsp_ok,
  output logic [3:0]              rsp_err,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id
);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      g_q, g_d, last_q, last_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ok_q, ok_d;
  logic [3:0]            err_q, err_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  lane_v, lane_last, hs_last;
  logic [DATA_W-1:0]     lane_data;

  json_rr_picker #(.N(N_REQ)) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  assign lane_v    = req_valid[g_q];
  assign lane_last = req_last[g_q];
  assign lane_data = req_data[int'(g_q)*DATA_W +: DATA_W];
  assign hs_last   = lane_v & dec_ready & lane_last;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    ok_d      = ok_q;
    err_d     = err_q;
    cnt_d     = '0;
    req_ready = '0;
    dec_valid = 1'b0;
    dec_data  = '0;
    dec_last  = 1'b0;
    dec_abort = 1'b0;
    rsp_valid = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          state_d = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        dec_valid      = lane_v;
        dec_data       = lane_data;
        dec_last       = lane_last;
        req_ready[g_q] = dec_ready;
        // an early verdict means the rest of the document is junk to the decoder
        if (dec_res_valid) begin
          ok_d    = dec_res_ok;
          err_d   = dec_res_err;
          state_d = hs_last ? ARB_RESP : ARB_DRAIN;
        end else if (hs_last) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_DRAIN: begin
        req_ready[g_q] = 1'b1;
        if (lane_v && lane_last) state_d = ARB_RESP;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (dec_res_valid) begin
          ok_d    = dec_res_ok;
          err_d   = dec_res_err;
          state_d = ARB_RESP;
        end else if (cnt_q == WAIT_CNT_W'(TIMEOUT - 1)) begin
          ok_d      = 1'b0;
          err_d     = JSON_ERR_TIMEOUT;
          dec_abort = 1'b1;
          state_d   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rsp_valid[g_q] = 1'b1;
        last_d         = g_q;
        state_d        = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= JSON_ERR_NONE;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign rsp_ok   = (state_q == ARB_RESP) & ok_q;
  assign rsp_err  = (state_q == ARB_RESP) ? err_q : JSON_ERR_NONE;
  assign busy     = (state_q != ARB_IDLE);
  assign grant_id = g_q;

endmodule

// File: tb/tb_json_decode_arbiter.sv
// Scoreboard bench for json_decode_arbiter: lane byte queues, a small decoder
// model, and expected byte/response queues checked as the DUT produces them.
module tb_json_decode_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam logic [3:0] E_INV_CHAR = 4'd7;
  localparam logic [3:0] E_TIMEOUT  = 4'd15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            dec_valid, dec_last, dec_ready, dec_abort;
  logic [DW-1:0]   dec_data;
  logic            dec_res_valid, dec_res_ok;
  logic [3:0]      dec_res_err;
  logic [N-1:0]    rsp_valid;
  logic            rsp_ok;
  logic [3:0]      rsp_err;
  logic            busy;
  logic [1:0]      grant_id;

  json_decode_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_last(dec_last), .dec_ready(dec_ready),
    .dec_abort(dec_abort), .dec_res_valid(dec_res_valid), .dec_res_ok(dec_res_ok),
    .dec_res_err(dec_res_err), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  logic [8:0] lane_q[N][$];
  logic [8:0] exp_bytes[$];
  logic [8:0] exp_rsp[$];

  int n_chk = 0, n_fail = 0;
  int tick_no = 0, exp_rsp_tick = -1;
  int doc_bytes = 0, drained = 0, aborts = 0;
  int verd_delay = -1, early_at = -1, wcnt = 0, cur_w = -1;
  bit inwait = 0, early_done = 0, rdy_tog = 0;
  logic verd_ok = 1'b1;
  logic [3:0] verd_err = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, tick_no);
    end
  endtask

  task automatic send_doc(input int lane, input int n, input logic [7:0] base, input int n_exp);
    for (int k = 0; k < n; k++) begin
      logic [8:0] b;
      b = {logic'(k == n - 1), base + 8'(k)};
      lane_q[lane].push_back(b);
      if (k < n_exp) exp_bytes.push_back(b);
    end
  endtask

  task automatic exp_resp(input int lane, input logic ok, input logic [3:0] err);
    exp_rsp.push_back({4'(1 << lane), ok, err});
  endtask

  task automatic out_zero_chk();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_data",  32'(dec_data), 0);
    chk("rst_dec_last",  32'(dec_last), 0);
    chk("rst_dec_abort", 32'(dec_abort), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_ok",    32'(rsp_ok), 0);
    chk("rst_rsp_err",   32'(rsp_err), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_grant_id",  32'(grant_id), 0);
  endtask

  // One cycle: drive at negedge, observe 1ns later (what the next posedge sees).
  task automatic tick();
    logic [3:0] allowed;
    logic [8:0] e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = lane_q[i].size() > 0;
      req_data[i*DW +: DW] = req_valid[i] ? lane_q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? lane_q[i][0][8] : 1'b0;
    end
    dec_ready = rdy_tog ? 1'(tick_no % 2) : 1'b1;
    dec_res_valid = 1'b0; dec_res_ok = 1'b0; dec_res_err = 4'd0;
    cur_w = -1;
    if (inwait) begin
      cur_w = wcnt;
      if (verd_delay == wcnt) begin
        dec_res_valid = 1'b1; dec_res_ok = verd_ok; dec_res_err = verd_err;
        inwait = 0;
        exp_rsp_tick = tick_no + 1;
      end
      wcnt++;
    end else if (early_at > 0 && !early_done && doc_bytes == early_at - 1) begin
      dec_res_valid = 1'b1; dec_res_ok = verd_ok; dec_res_err = verd_err;
      early_done = 1;
    end
    #1;
    if (dec_valid && dec_ready) begin
      if (exp_bytes.size() == 0) chk("dec_extra", 1, 0);
      else begin
        e = exp_bytes.pop_front();
        chk("dec_byte", 32'({dec_last, dec_data}), 32'(e));
      end
      doc_bytes++;
      if (dec_last) begin inwait = 1; wcnt = 0; end
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        if (!dec_valid) begin
          drained++;
          if (req_last[i]) exp_rsp_tick = tick_no + 1;
        end
        void'(lane_q[i].pop_front());
      end
    allowed = busy ? 4'(1 << grant_id) : 4'b0;
    chk("rdy_mask", 32'(req_ready & ~allowed), 0);
    if (dec_abort) begin
      aborts++;
      chk("abort_cyc", 32'(cur_w), TO - 1);
      inwait = 0;
      exp_rsp_tick = tick_no + 1;
    end
    if (rsp_valid != '0) begin
      if (exp_rsp.size() == 0) chk("rsp_extra", 32'(rsp_valid), 0);
      else begin
        e = exp_rsp.pop_front();
        chk("rsp", 32'({rsp_valid, rsp_ok, rsp_err}), 32'(e));
        chk("rsp_lat", 32'(tick_no), 32'(exp_rsp_tick));
      end
      doc_bytes = 0;
      early_done = 0;
    end
    tick_no++;
  endtask

  task automatic run();
    int budget = 200;
    while (exp_rsp.size() > 0 && budget > 0) begin tick(); budget--; end
    if (budget == 0) chk("run_budget", 0, 1);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    dec_ready = 1'b1; dec_res_valid = 1'b0; dec_res_ok = 1'b0; dec_res_err = 4'd0;
    #2;
    out_zero_chk();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // round robin: 0,1,2,3 then lane 0 again
    verd_delay = 0; verd_ok = 1'b1; verd_err = 4'd0;
    for (int l = 0; l < N; l++) send_doc(l, 1, 8'(8'h10 + l * 16), 1);
    send_doc(0, 1, 8'h55, 1);
    for (int l = 0; l < N; l++) exp_resp(l, 1'b1, 4'd0);
    exp_resp(0, 1'b1, 4'd0);
    run();

    // single 5-byte document on lane 2, verdict at wait cycle 3
    verd_delay = 3;
    send_doc(2, 5, 8'h61, 5);
    exp_resp(2, 1'b1, 4'd0);
    tick();
    chk("idle_before_grant", 32'(busy), 0);
    tick();
    chk("grant_lat", 32'(dec_valid), 1);
    chk("grant_id", 32'(grant_id), 2);
    run();

    // early error after byte 3 of 10 on lane 1
    verd_delay = -1; verd_ok = 1'b0; verd_err = E_INV_CHAR; early_at = 3;
    send_doc(1, 10, 8'h30, 3);
    exp_resp(1, 1'b0, E_INV_CHAR);
    run();
    early_at = -1;
    chk("drained", 32'(drained), 7);

    // decoder silent: forced timeout
    verd_delay = -1;
    send_doc(0, 3, 8'h70, 3);
    exp_resp(0, 1'b0, E_TIMEOUT);
    run();

    // verdict on the timeout cycle wins
    verd_delay = TO - 1; verd_ok = 1'b1; verd_err = 4'd0;
    send_doc(3, 2, 8'h90, 2);
    exp_resp(3, 1'b1, 4'd0);
    run();

    // decoder backpressure every other cycle
    rdy_tog = 1; verd_delay = 1;
    send_doc(3, 6, 8'hA0, 6);
    exp_resp(3, 1'b1, 4'd0);
    run();
    rdy_tog = 0;

    // reset in the middle of a stream
    verd_delay = 2;
    send_doc(2, 10, 8'hC0, 10);
    budget = 50;
    while (doc_bytes < 3 && budget > 0) begin tick(); budget--; end
    if (budget == 0) chk("stream_budget", 0, 1);
    for (int l = 0; l < N; l++) lane_q[l].delete();
    exp_bytes.delete(); exp_rsp.delete();
    inwait = 0; doc_bytes = 0;
    rst_n = 1'b0;
    #1;
    out_zero_chk();
    tick(); tick();
    rst_n = 1'b1;
    send_doc(0, 2, 8'hD0, 2);
    send_doc(2, 2, 8'hE0, 2);
    exp_resp(0, 1'b1, 4'd0);
    exp_resp(2, 1'b1, 4'd0);
    run();

    chk("aborts", 32'(aborts), 1);
    chk("sb_empty", 32'(exp_bytes.size() + exp_rsp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
